// File: rtl/sseg_serial_rx_pkg.sv
// Shared seven-segment constants used by both the display driver side and
// the serial receiver: active-low {g,f,e,d,c,b,a} patterns for hex 0-F and
// the frame geometry.
package sseg_serial_rx_pkg;

    localparam int FRAME_BITS = 64;
    localparam int DIGITS     = 8;
    localparam int CNT_W      = 6;

    // Index = hex value, 0 = segment lit.
    localparam logic [6:0] SEG_PATTERNS [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/sseg_serial_rx_seg_decode.sv
// Inverse seven-segment lookup: exact match of a 7-bit active-low pattern
// against the 16 hex glyphs. Anything else decodes to nibble 0 with ok low.
module seg_decode
    import sseg_serial_rx_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] nibble,
    output logic       ok
);

    logic [15:0] match;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_match
            assign match[gi] = (seg == SEG_PATTERNS[gi]);
        end
    endgenerate

    // Patterns are unique, so OR-ing the indices of the matches is one-hot safe.
    always_comb begin
        nibble = 4'd0;
        for (int k = 0; k < 16; k++) begin
            if (match[k]) begin
                nibble = nibble | 4'(k);
            end
        end
    end

    assign ok = |match;

endmodule

// File: rtl/sseg_serial_rx.sv
// Receives 64-bit seven-segment frames shifted out by a display driver on
// an asynchronous serial clock, decodes the eight digits and presents the
// last accepted frame, its decode and a frame counter.
module sseg_serial_rx
    import sseg_serial_rx_pkg::*;
#(
    parameter int SYNC_STAGES = 2   // must be at least 2
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        seg_clk,
    input  logic        seg_sout,
    input  logic        seg_clrn,
    input  logic        SEG_PEN,
    output logic [63:0] frame,
    output logic        frame_valid,
    output logic [31:0] hexs,
    output logic [7:0]  digit_ok,
    output logic [7:0]  points,
    output logic [7:0]  frame_cnt
);

    logic [SYNC_STAGES-1:0] clk_sync_reg;
    logic [SYNC_STAGES-1:0] sout_sync_reg;
    logic [SYNC_STAGES-1:0] clrn_sync_reg;
    logic [SYNC_STAGES-1:0] pen_sync_reg;

    logic                   seg_clk_prev_reg;
    logic [FRAME_BITS-1:0]  shift_reg;
    logic [CNT_W-1:0]       bit_cnt_reg;
    logic [FRAME_BITS-1:0]  frame_reg;
    logic [31:0]            hexs_reg;
    logic [7:0]             digit_ok_reg;
    logic [7:0]             points_reg;
    logic                   frame_valid_reg;
    logic [7:0]             frame_cnt_reg;

    logic                   seg_clk_s;
    logic                   seg_sout_s;
    logic                   seg_clrn_s;
    logic                   seg_pen_s;
    logic                   seg_clk_rise;
    logic                   last_bit;
    logic [FRAME_BITS-1:0]  shift_next;
    logic [31:0]            hexs_next;
    logic [7:0]             digit_ok_next;
    logic [7:0]             points_next;

    // All four inputs share the same synchronizer depth so that data, clear
    // and enable stay aligned with the synchronized shift clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync_reg  <= '0;
            sout_sync_reg <= '0;
            clrn_sync_reg <= '0;
            pen_sync_reg  <= '0;
        end else begin
            clk_sync_reg  <= {clk_sync_reg[SYNC_STAGES-2:0],  seg_clk};
            sout_sync_reg <= {sout_sync_reg[SYNC_STAGES-2:0], seg_sout};
            clrn_sync_reg <= {clrn_sync_reg[SYNC_STAGES-2:0], seg_clrn};
            pen_sync_reg  <= {pen_sync_reg[SYNC_STAGES-2:0],  SEG_PEN};
        end
    end

    assign seg_clk_s    = clk_sync_reg[SYNC_STAGES-1];
    assign seg_sout_s   = sout_sync_reg[SYNC_STAGES-1];
    assign seg_clrn_s   = clrn_sync_reg[SYNC_STAGES-1];
    assign seg_pen_s    = pen_sync_reg[SYNC_STAGES-1];
    assign seg_clk_rise = seg_clk_s & ~seg_clk_prev_reg;
    assign last_bit     = (bit_cnt_reg == CNT_W'(FRAME_BITS - 1));

    // MSB-first: the first bit received ends up in bit 63 (digit 7 dp).
    assign shift_next = {shift_reg[FRAME_BITS-2:0], seg_sout_s};

    // Decode the frame as it will look after this capture, so the registered
    // outputs update on the very cycle the 64th bit lands.
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            seg_decode u_seg_decode (
                .seg    (shift_next[8*gi +: 7]),
                .nibble (hexs_next[4*gi +: 4]),
                .ok     (digit_ok_next[gi])
            );
            assign points_next[gi] = ~shift_next[8*gi + 7];
        end
    endgenerate

    // Edge detection, bit capture, frame acceptance and the frame counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_clk_prev_reg <= 1'b0;
            shift_reg        <= '0;
            bit_cnt_reg      <= '0;
            frame_reg        <= '0;
            hexs_reg         <= '0;
            digit_ok_reg     <= '0;
            points_reg       <= '0;
            frame_valid_reg  <= 1'b0;
            frame_cnt_reg    <= '0;
        end else begin
            seg_clk_prev_reg <= seg_clk_s;
            frame_valid_reg  <= 1'b0;
            if (!seg_clrn_s) begin
                // Clear wins over a coincident edge; the partial frame is dropped.
                bit_cnt_reg <= '0;
            end else if (seg_clk_rise) begin
                shift_reg   <= shift_next;
                bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
                if (last_bit && seg_pen_s) begin
                    frame_reg       <= shift_next;
                    hexs_reg        <= hexs_next;
                    digit_ok_reg    <= digit_ok_next;
                    points_reg      <= points_next;
                    frame_valid_reg <= 1'b1;
                    frame_cnt_reg   <= frame_cnt_reg + 8'd1;
                end
            end
        end
    end

    assign frame       = frame_reg;
    assign frame_valid = frame_valid_reg;
    assign hexs        = hexs_reg;
    assign digit_ok    = digit_ok_reg;
    assign points      = points_reg;
    assign frame_cnt   = frame_cnt_reg;

endmodule

// File: tb/tb_sseg_serial_rx.sv
// Table-driven bench for sseg_serial_rx with a scoreboard of expected
// frames, plus hand sequences for clear, discard, back-to-back and reset.
module tb_sseg_serial_rx;

    localparam int SS = 2;      // synchronizer depth under test
    localparam int PH = 5;      // seg_clk phase length in clk cycles

    logic        clk = 1'b0;
    logic        rst;
    logic        seg_clk;
    logic        seg_sout;
    logic        seg_clrn;
    logic        SEG_PEN;
    logic [63:0] frame;
    logic        frame_valid;
    logic [31:0] hexs;
    logic [7:0]  digit_ok;
    logic [7:0]  points;
    logic [7:0]  frame_cnt;

    sseg_serial_rx #(.SYNC_STAGES(SS)) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_clk     (seg_clk),
        .seg_sout    (seg_sout),
        .seg_clrn    (seg_clrn),
        .SEG_PEN     (SEG_PEN),
        .frame       (frame),
        .frame_valid (frame_valid),
        .hexs        (hexs),
        .digit_ok    (digit_ok),
        .points      (points),
        .frame_cnt   (frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] bits;
        logic        pen;
        logic [31:0] hexs;
        logic [7:0]  ok;
        logic [7:0]  pts;
    } vec_t;

    typedef struct {
        logic [63:0] frame;
        logic [31:0] hexs;
        logic [7:0]  ok;
        logic [7:0]  pts;
        logic [7:0]  cnt;
    } exp_t;

    exp_t q[$];
    exp_t last_exp;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   last_edge_cyc = 0;
    int   pulses = 0;
    logic [7:0] model_cnt = 8'd0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every pulse must match the oldest expected frame.
    always @(negedge clk) begin
        if (!rst && frame_valid) begin
            pulses++;
            if (q.size() == 0) begin
                chk("unexpected_pulse", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                $display("frame cnt=%0d frame=%016h hexs=%08h ok=%02h pts=%02h", frame_cnt, frame, hexs, digit_ok, points);
                chk("frame",    frame,     e.frame);
                chk("hexs",     hexs,      64'(e.hexs));
                chk("digit_ok", digit_ok,  64'(e.ok));
                chk("points",   points,    64'(e.pts));
                chk("frame_cnt", frame_cnt, 64'(e.cnt));
                chk("latency",  64'(cyc - last_edge_cyc), 64'(SS + 1));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        seg_clk  = 1'b0;
        seg_sout = b;
        tick(PH);
        seg_clk = 1'b1;
        last_edge_cyc = cyc;
        tick(PH);
    endtask

    task automatic send_frame(input logic [63:0] f, input logic pen,
                              input logic [31:0] h, input logic [7:0] ok, input logic [7:0] pts);
        exp_t e;
        SEG_PEN = pen;
        if (pen) begin
            model_cnt = model_cnt + 8'd1;
            e.frame = f; e.hexs = h; e.ok = ok; e.pts = pts; e.cnt = model_cnt;
            q.push_back(e);
            last_exp = e;
        end
        for (int i = 63; i >= 0; i--) send_bit(f[i]);
    endtask

    task automatic drain(input string name);
        int waited;
        waited = 0;
        while (q.size() != 0 && waited < 20) begin
            tick(1);
            waited++;
        end
        chk(name, 64'(q.size()), 64'd0);
    endtask

    task automatic check_held(input string name);
        chk({name, "_frame"}, frame,     last_exp.frame);
        chk({name, "_hexs"},  hexs,      64'(last_exp.hexs));
        chk({name, "_ok"},    digit_ok,  64'(last_exp.ok));
        chk({name, "_pts"},   points,    64'(last_exp.pts));
        chk({name, "_cnt"},   frame_cnt, 64'(last_exp.cnt));
    endtask

    task automatic check_zero(input string name);
        chk({name, "_frame"}, frame,     64'd0);
        chk({name, "_hexs"},  hexs,      64'd0);
        chk({name, "_ok"},    digit_ok,  64'd0);
        chk({name, "_pts"},   points,    64'd0);
        chk({name, "_cnt"},   frame_cnt, 64'd0);
        chk({name, "_valid"}, frame_valid, 64'd0);
    endtask

    vec_t vecs[7];

    initial begin
        int p0;
        vecs[0] = '{64'hF8_82_92_99_B0_A4_F9_C0, 1'b1, 32'h76543210, 8'hFF, 8'h00};
        vecs[1] = '{64'hFF_FF_FF_FF_FF_FF_FF_00, 1'b1, 32'h00000008, 8'h01, 8'h01};
        vecs[2] = '{64'h7F_7F_7F_7F_7F_7F_7F_7F, 1'b1, 32'h00000000, 8'h00, 8'hFF};
        vecs[3] = '{64'h8E_86_A1_C6_83_88_90_00, 1'b1, 32'hFEDCBA98, 8'hFF, 8'h01};
        vecs[4] = '{64'hC1_C1_C1_C1_C1_C1_C1_C1, 1'b1, 32'h00000000, 8'h00, 8'h00};
        vecs[5] = '{64'h40_40_40_40_40_40_40_40, 1'b0, 32'h00000000, 8'hFF, 8'hFF};
        vecs[6] = '{64'h40_79_24_30_19_12_02_78, 1'b1, 32'h01234567, 8'hFF, 8'hFF};

        rst = 1'b1; seg_clk = 1'b0; seg_sout = 1'b0; seg_clrn = 1'b1; SEG_PEN = 1'b0;
        last_exp = '{64'd0, 32'd0, 8'd0, 8'd0, 8'd0};
        tick(4);
        check_zero("reset");
        rst = 1'b0;
        tick(6);

        // Table: accepted frames go through the scoreboard, discarded ones
        // must leave every output and the pulse count untouched.
        for (int i = 0; i < 7; i++) begin
            p0 = pulses;
            send_frame(vecs[i].bits, vecs[i].pen, vecs[i].hexs, vecs[i].ok, vecs[i].pts);
            tick(10);
            if (vecs[i].pen) begin
                drain("drain_vec");
                chk("pulse_count", 64'(pulses - p0), 64'd1);
            end else begin
                $display("frame discarded (SEG_PEN low) bits=%016h", vecs[i].bits);
                chk("discard_pulses", 64'(pulses - p0), 64'd0);
                check_held("discard");
            end
        end

        // 30 bits, clear pulse, then one full frame: only that frame appears.
        p0 = pulses;
        SEG_PEN = 1'b1;
        for (int i = 0; i < 30; i++) send_bit(1'($urandom_range(0, 1)));
        seg_clk = 1'b0;
        tick(PH);
        seg_clrn = 1'b0;
        tick(6);
        seg_clrn = 1'b1;
        tick(6);
        send_frame(vecs[3].bits, 1'b1, vecs[3].hexs, vecs[3].ok, vecs[3].pts);
        tick(10);
        drain("drain_clrn");
        chk("clrn_pulses", 64'(pulses - p0), 64'd1);

        // 128 contiguous edges: two back-to-back frames.
        p0 = pulses;
        send_frame(vecs[0].bits, 1'b1, vecs[0].hexs, vecs[0].ok, vecs[0].pts);
        send_frame(vecs[6].bits, 1'b1, vecs[6].hexs, vecs[6].ok, vecs[6].pts);
        tick(10);
        drain("drain_b2b");
        chk("b2b_pulses", 64'(pulses - p0), 64'd2);

        // Reset 40 bits into a third frame.
        for (int i = 0; i < 40; i++) send_bit(1'($urandom_range(0, 1)));
        seg_clk = 1'b0;
        rst = 1'b1;
        tick(2);
        check_zero("midrst");
        rst = 1'b0;
        model_cnt = 8'd0;
        tick(6);
        check_zero("postrst");
        p0 = pulses;
        send_frame(vecs[1].bits, 1'b1, vecs[1].hexs, vecs[1].ok, vecs[1].pts);
        tick(10);
        drain("drain_rst");
        chk("rst_pulses", 64'(pulses - p0), 64'd1);
        chk("rst_cnt", frame_cnt, 64'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Hard ceiling so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
